uart_rx_fifo: RTL and testbench

Receive-side buffer that sits directly downstream of the UART receiver and consumes its byte output. It detects each newly completed frame from the receiver's data-valid level and pushes the byte into a register-array FIFO. It presents bytes to the consumer on a ready/valid interface and reports full, empty, occupancy and a sticky overflow flag.

---
 rtl/uart_rx_fifo.sv | 99 +++++++++
 tb/tb_uart_rx_fifo.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver: edge-detects data-valid, buffers bytes, FWFT ready/valid output.
// Optional almost-full output enabled by defining UART_RX_FIFO_AFULL_EN.
module uart_rx_fifo #(
  parameter int DATA_WIDTH   = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [DATA_WIDTH-1:0]    rx_data_i,
  input  logic                     rx_data_valid_i,
  input  logic                     rx_err_i,
  output logic [DATA_WIDTH-1:0]    m_data_o,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     overflow_o,
  input  logic                     clear_overflow_i
`ifdef UART_RX_FIFO_AFULL_EN
  ,
  output logic                     almost_full_o
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0] AFULL_C = AFULL_THRESH[AW:0];

  // Reject configurations the pointer wrap and threshold compare cannot support.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH || AFULL_C == '0) begin : g_bad_thresh
    $error("uart_rx_fifo: AFULL_THRESH must be in 1..DEPTH");
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         rd_ptr;
  logic [AW-1:0]         wr_ptr;
  logic                  valid_q;
  logic                  wr_stb;
  logic                  push;
  logic                  pop;
  logic                  drop;

  assign full_o    = (count_o == DEPTH_C);
  assign empty_o   = (count_o == '0);
  assign m_valid_o = ~empty_o;
  assign m_data_o  = mem[rd_ptr];

  assign wr_stb = rx_data_valid_i & ~valid_q & ~rx_err_i;
  assign pop    = m_valid_o & m_ready_i;
  // A simultaneous pop frees the slot, so a full FIFO can still accept the byte.
  assign push   = wr_stb & (~full_o | pop);
  assign drop   = wr_stb & full_o & ~pop;

`ifdef UART_RX_FIFO_AFULL_EN
  assign almost_full_o = (count_o >= AFULL_C);
`endif

  // Storage is not reset; contents are qualified by count/m_valid_o.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= rx_data_i;
    end
  end

  // valid_q resets high so a level still asserted after reset is not taken as a new frame.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_o    <= '0;
      valid_q    <= 1'b1;
      overflow_o <= 1'b0;
    end else begin
      valid_q <= rx_data_valid_i;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count_o <= count_o + 1'b1;
      end else if (pop && !push) begin
        count_o <= count_o - 1'b1;
      end
      if (drop) begin
        overflow_o <= 1'b1;
      end else if (clear_overflow_i) begin
        overflow_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: directed scenarios plus randomized traffic against a queue-based reference model.
// Define UART_RX_FIFO_AFULL_EN to also exercise almost_full_o.
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFT   = 12;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [DW-1:0] rx_data_i;
  logic          rx_data_valid_i;
  logic          rx_err_i;
  logic [DW-1:0] m_data_o;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [CW-1:0] count_o;
  logic          full_o;
  logic          empty_o;
  logic          overflow_o;
  logic          clear_overflow_i;
`ifdef UART_RX_FIFO_AFULL_EN
  logic          almost_full_o;
`endif

  uart_rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THRESH(AFT)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .rx_data_i        (rx_data_i),
    .rx_data_valid_i  (rx_data_valid_i),
    .rx_err_i         (rx_err_i),
    .m_data_o         (m_data_o),
    .m_valid_o        (m_valid_o),
    .m_ready_i        (m_ready_i),
    .count_o          (count_o),
    .full_o           (full_o),
    .empty_o          (empty_o),
    .overflow_o       (overflow_o),
    .clear_overflow_i (clear_overflow_i)
`ifdef UART_RX_FIFO_AFULL_EN
    ,
    .almost_full_o    (almost_full_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the FIFO as a queue, previous valid level, sticky overflow.
  logic [DW-1:0] model_q[$];
  logic          model_prev;
  logic          model_ovf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic compare_model();
    check("count", 32'(count_o), 32'(model_q.size()));
    check("empty", 32'(empty_o), 32'(model_q.size() == 0));
    check("full", 32'(full_o), 32'(model_q.size() == DEPTH));
    check("m_valid", 32'(m_valid_o), 32'(model_q.size() != 0));
    check("overflow", 32'(overflow_o), 32'(model_ovf));
    if (model_q.size() != 0) check("m_data", 32'(m_data_o), 32'(model_q[0]));
`ifdef UART_RX_FIFO_AFULL_EN
    check("almost_full", 32'(almost_full_o), 32'(model_q.size() >= AFT));
`endif
  endtask

  // One clock: apply inputs, compare current outputs, advance the model, step past the edge.
  task automatic cycle(input logic v, input logic [DW-1:0] d, input logic e,
                       input logic r, input logic c);
    logic stb, was_full, popped, set_ovf;
    rx_data_valid_i  = v;
    rx_data_i        = d;
    rx_err_i         = e;
    m_ready_i        = r;
    clear_overflow_i = c;
    #1;
    compare_model();
    stb      = v && !model_prev && !e;
    was_full = (model_q.size() == DEPTH);
    popped   = (model_q.size() != 0) && r;
    set_ovf  = 1'b0;
    if (popped) void'(model_q.pop_front());
    if (stb) begin
      if (!was_full || popped) model_q.push_back(d);
      else set_ovf = 1'b1;
    end
    if (set_ovf) model_ovf = 1'b1;
    else if (c) model_ovf = 1'b0;
    model_prev = v;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    #2;
    model_q.delete();
    model_prev = 1'b1;
    model_ovf  = 1'b0;
    compare_model();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic push_byte(input logic [DW-1:0] d);
    cycle(1'b1, d, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, d, 1'b0, 1'b0, 1'b0);
  endtask

  logic          rv;
  logic [DW-1:0] rd;
  int            rdy_pct;

  initial begin
    rst_ni = 1'b1;
    rx_data_valid_i = 1'b1;
    rx_data_i = '0;
    rx_err_i = 1'b0;
    m_ready_i = 1'b0;
    clear_overflow_i = 1'b0;
    model_prev = 1'b1;
    model_ovf = 1'b0;
    @(posedge clk_i);
    #1;

    // Reset with valid held high: nothing captured after release.
    do_reset();
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'hC3, 1'b0, 1'b1, 1'b0);
    check("t1_count", 32'(count_o), 32'd0);
    check("t1_valid", 32'(m_valid_o), 32'd0);

    // Three frames, one valid level held 3 cycles.
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    push_byte(8'h55);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hA3, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'hA3, 1'b0, 1'b0, 1'b0);
    push_byte(8'h0F);
    check("t2_count", 32'(count_o), 32'd3);
    check("t2_d0", 32'(m_data_o), 32'h55);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("t2_d1", 32'(m_data_o), 32'hA3);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("t2_d2", 32'(m_data_o), 32'h0F);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("t2_empty", 32'(empty_o), 32'd1);

    // Overfill by one byte.
    for (int i = 0; i <= 16; i++) push_byte(DW'(i));
    check("t3_full", 32'(full_o), 32'd1);
    check("t3_count", 32'(count_o), 32'd16);
    check("t3_ovf", 32'(overflow_o), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("t3_drain", 32'(m_data_o), 32'(i));
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end
    check("t3_empty", 32'(empty_o), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("t3_clr", 32'(overflow_o), 32'd0);

    // Full with coincident strobe and pop.
    for (int i = 0; i < 16; i++) push_byte(DW'(i));
    check("t4_head", 32'(m_data_o), 32'h00);
    cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
    check("t4_count", 32'(count_o), 32'd16);
    check("t4_ovf", 32'(overflow_o), 32'd0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check("t4_last", 32'(m_data_o), 32'h77);
      cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    end

    // Error suppresses the strobe.
    cycle(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 8'hEE, 1'b0, 1'b0, 1'b0);
    check("t5_count", 32'(count_o), 32'd0);
    push_byte(8'h11);
    check("t5_push", 32'(count_o), 32'd1);
    check("t5_data", 32'(m_data_o), 32'h11);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Set and clear of overflow in the same cycle: set wins.
    for (int i = 0; i < 16; i++) push_byte(8'hB0);
    cycle(1'b1, 8'hBF, 1'b0, 1'b0, 1'b1);
    check("t_setwins", 32'(overflow_o), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    // Reset mid-operation discards the contents.
    do_reset();
    check("midrst_count", 32'(count_o), 32'd0);

`ifdef UART_RX_FIFO_AFULL_EN
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) push_byte(DW'(i));
    check("t6_af11", 32'(almost_full_o), 32'd0);
    cycle(1'b1, 8'h0B, 1'b0, 1'b0, 1'b0);
    check("t6_af12", 32'(almost_full_o), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("t6_afpop", 32'(almost_full_o), 32'd0);
    for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
`endif

    // Randomized traffic with shifting consumer pressure.
    rv = 1'b0;
    rdy_pct = 50;
    for (int n = 0; n < 4000; n++) begin
      if (n % 500 == 0) rdy_pct = (n / 500) % 3 == 0 ? 15 : ((n / 500) % 3 == 1 ? 50 : 90);
      if ($urandom_range(0, 2) == 0) rv = ~rv;
      rd = DW'($urandom);
      if ($urandom_range(0, 1499) == 0) do_reset();
      cycle(rv, rd, $urandom_range(0, 15) == 0, $urandom_range(0, 99) < rdy_pct,
            $urandom_range(0, 19) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
